ntt_bank_write_arbiter: RTL and testbench
=========================================

# ntt_bank_write_arbiter

Two-requester arbiter for the shared write port into the NTT coefficient memory banks. Requester 0 is the input loader and requester 1 is the butterfly writeback path. Each cycle the block grants at most one write by round-robin. It registers the granted bank index, address and data, and steers the data onto the selected bank's slice with a one-hot write enable, using the 1-to-S demux semantics of the bank datapath. It also keeps a saturating contention counter and a sticky bad-bank flag for debug.

## Interface
- N, default 16: coefficient data width.
- S, default 4: number of banks; need not be a power of 2. Let SEL_W = $clog2(S) and SP = 2**SEL_W.
- A, default 8: per-bank address width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req0_valid  in  1  loader write request.
- req0_ready  out  1  loader request granted this cycle.
- req0_bank  in  SEL_W  target bank index.
- req0_addr  in  A  word address within the bank.
- req0_data  in  N  coefficient.
- req1_valid, req1_ready, req1_bank, req1_addr, req1_data: same as req0, for the writeback requester.
- bank_we  out  SP  one-hot write enable, registered.
- bank_addr  out  A  address shared by all banks, registered.
- bank_data  out  SP*N  demuxed data: slice k = bank_data[(k+1)*N-1:k*N]. Registered.
- last_grant  out  1  id of the most recently granted requester.
- conflict_cnt  out  16  count of cycles in which both requesters were valid; saturates at 0xFFFF.
- bad_bank  out  1  sticky flag; set when an accepted request has bank index >= S.

## Operation
- Handshake: a transfer on requester i occurs when reqi_valid && reqi_ready.
  - Once valid is raised, the requester holds valid, bank, addr and data stable until ready.
  - The arbiter makes no assumption that a request can be withdrawn.
- reqi_ready is combinational from both valids and last_grant:
  - Only one requester valid: that requester gets ready.
  - Both valid: the requester that is not last_grant gets ready (round-robin).
  - Neither valid: both readys are 0.
  - At most one ready is high in any cycle.
- The output stage never stalls because the banks always accept. The arbiter therefore grants in every cycle that has at least one valid request, giving full throughput.
- On each transfer, with winning requester w, the next edge registers:
  - bank_addr <= reqw_addr.
  - bank_we <= one-hot at reqw_bank.
  - bank_data: slice reqw_bank <= reqw_data; every other slice <= 0.
  - last_grant <= w.
- Cycle with no transfer:
  - bank_we <= 0 and bank_data <= 0.
  - bank_addr holds its value.
  - last_grant holds its value.
- Bank index >= S (only possible when S is not a power of 2):
  - The transfer is still accepted and consumed.
  - bank_we <= 0 and bank_data <= 0, so no bank is written.
  - bad_bank <= 1 and stays set until rst.
- conflict_cnt increments by 1 on every edge where req0_valid && req1_valid, and holds at 0xFFFF once reached.

## Timing
- Reset values: bank_we = 0, bank_addr = 0, bank_data = 0, last_grant = 1 (so req0 wins the first contention), conflict_cnt = 0, bad_bank = 0.
- Latency: a transfer at edge t appears on the bank_* outputs in the cycle after edge t, which is 1 cycle.
- bank_we is high for exactly one cycle per accepted request.
- Sustained contention: grants strictly alternate 0, 1, 0, 1, …, so each requester receives 50% of cycles.
- Single active requester: 1 grant per cycle, with no bubble after the other requester drops.
- Reset asserted mid-stream: all outputs clear asynchronously and the pending output write is dropped. After release, arbitration restarts with req0 favored.

## Test plan
- Reset check: drive rst high, then release. Required: every output at its reset value, and req0_ready == req0_valid from the first cycle.
- Single requester: req0 streams 8 writes, bank = k%4, addr = k, data = 0x100+k, back-to-back; req1 idle. Required:
  - req0_ready high every cycle.
  - bank_we = 1<<(k%4) one cycle later.
  - Slice k%4 = 0x100+k; all other slices 0.
- Contention: both requesters valid continuously for 10 cycles. Required:
  - Grants 0, 1, 0, 1, …
  - conflict_cnt = 10.
  - The loser's payload is held and written after its grant.
- Simultaneous handoff: req1 asserts in the same cycle that req0 drops. Required: req1 is granted immediately, with no idle cycle on bank_we.
- Bad bank: S = 3, req0 sends bank = 3, addr = 0x05. Required:
  - req0_ready = 1.
  - Next cycle bank_we = 0 and bank_data = 0.
  - bad_bank = 1 and stays set until rst.
- Mid-stream reset, then saturation:
  - rst pulses while bank_we is pending. Required: bank_we clears immediately.
  - Force 70000 contention cycles. Required: conflict_cnt = 0xFFFF.

Source files
------------

// File: rtl/ntt_bank_write_arbiter_if.sv
// rtl/ntt_bank_write_arbiter_if.sv - two-requester write bus into the NTT bank arbiter
interface ntt_bank_write_arbiter_if #(
    parameter int N = 16,
    parameter int S = 4,
    parameter int A = 8
);
    localparam int SEL_W = $clog2(S);

    logic             req0_valid;
    logic             req0_ready;
    logic [SEL_W-1:0] req0_bank;
    logic [A-1:0]     req0_addr;
    logic [N-1:0]     req0_data;

    logic             req1_valid;
    logic             req1_ready;
    logic [SEL_W-1:0] req1_bank;
    logic [A-1:0]     req1_addr;
    logic [N-1:0]     req1_data;

    modport master (
        output req0_valid, req0_bank, req0_addr, req0_data,
        output req1_valid, req1_bank, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_bank, req0_addr, req0_data,
        input  req1_valid, req1_bank, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/ntt_bank_write_arbiter.sv
// rtl/ntt_bank_write_arbiter.sv - round-robin arbiter and 1-to-S demux for the NTT bank write port
module ntt_bank_write_arbiter #(
    parameter int N = 16,
    parameter int S = 4,
    parameter int A = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    ntt_bank_write_arbiter_if.slave           bus,
    output logic [(2**$clog2(S))-1:0]         o_bank_we,
    output logic [A-1:0]                      o_bank_addr,
    output logic [(2**$clog2(S))*N-1:0]       o_bank_data,
    output logic                              o_last_grant,
    output logic [15:0]                       o_conflict_cnt,
    output logic                              o_bad_bank
);
    localparam int SEL_W = $clog2(S);
    localparam int SP    = 2**SEL_W;

    logic [SP-1:0]    r_bank_we;
    logic [A-1:0]     r_bank_addr;
    logic [SP*N-1:0]  r_bank_data;
    logic             r_last_grant;
    logic [15:0]      r_conflict_cnt;
    logic             r_bad_bank;

    logic             w_both;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_xfer;
    logic [SEL_W-1:0] w_sel_bank;
    logic [A-1:0]     w_sel_addr;
    logic [N-1:0]     w_sel_data;
    logic             w_bank_ok;
    logic [SP-1:0]    w_we_onehot;
    logic [SP*N-1:0]  w_data_demux;

    // Under contention the requester that did not win last time goes next.
    assign w_both = bus.req0_valid && bus.req1_valid;
    assign w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
    assign w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    assign w_xfer = w_gnt0 || w_gnt1;

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;

    assign w_sel_bank = w_gnt1 ? bus.req1_bank : bus.req0_bank;
    assign w_sel_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
    assign w_sel_data = w_gnt1 ? bus.req1_data : bus.req0_data;

    // Out-of-range indices only exist when S is not a power of two.
    generate
        if (S == SP) begin : g_full_range
            assign w_bank_ok = 1'b1;
        end else begin : g_partial_range
            assign w_bank_ok = (w_sel_bank < SEL_W'(S));
        end
    endgenerate

    assign w_we_onehot = SP'(1) << w_sel_bank;

    always_comb begin
        w_data_demux = '0;
        for (int k = 0; k < SP; k++) begin
            if (w_sel_bank == SEL_W'(k)) begin
                w_data_demux[k*N +: N] = w_sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank_we      <= '0;
            r_bank_addr    <= '0;
            r_bank_data    <= '0;
            r_last_grant   <= 1'b1;
            r_conflict_cnt <= '0;
            r_bad_bank     <= 1'b0;
        end else begin
            if (w_xfer && w_bank_ok) begin
                r_bank_we   <= w_we_onehot;
                r_bank_data <= w_data_demux;
            end else begin
                r_bank_we   <= '0;
                r_bank_data <= '0;
            end
            if (w_xfer) begin
                r_bank_addr  <= w_sel_addr;
                r_last_grant <= w_gnt1;
            end
            if (w_xfer && !w_bank_ok) begin
                r_bad_bank <= 1'b1;
            end
            if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end

    assign o_bank_we      = r_bank_we;
    assign o_bank_addr    = r_bank_addr;
    assign o_bank_data    = r_bank_data;
    assign o_last_grant   = r_last_grant;
    assign o_conflict_cnt = r_conflict_cnt;
    assign o_bad_bank     = r_bad_bank;
endmodule

// File: tb/tb_ntt_bank_write_arbiter.sv
// tb/tb_ntt_bank_write_arbiter.sv - scoreboard bench for ntt_bank_write_arbiter
module tb_ntt_bank_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_bank_write_arbiter_if #(.N(16), .S(4), .A(8)) bus ();
    ntt_bank_write_arbiter_if #(.N(16), .S(3), .A(8)) bus3 ();

    logic [3:0]  bank_we,  bank_we3;
    logic [7:0]  bank_addr, bank_addr3;
    logic [63:0] bank_data, bank_data3;
    logic        last_grant, last_grant3;
    logic [15:0] conflict_cnt, conflict_cnt3;
    logic        bad_bank, bad_bank3;

    ntt_bank_write_arbiter #(.N(16), .S(4), .A(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_bank_we(bank_we), .o_bank_addr(bank_addr), .o_bank_data(bank_data),
        .o_last_grant(last_grant), .o_conflict_cnt(conflict_cnt), .o_bad_bank(bad_bank)
    );

    ntt_bank_write_arbiter #(.N(16), .S(3), .A(8)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .o_bank_we(bank_we3), .o_bank_addr(bank_addr3), .o_bank_data(bank_data3),
        .o_last_grant(last_grant3), .o_conflict_cnt(conflict_cnt3), .o_bad_bank(bad_bank3)
    );

    typedef struct packed {
        logic [1:0]  bank;
        logic [7:0]  addr;
        logic [15:0] data;
    } pay_t;

    typedef struct packed {
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [63:0] data;
    } out_t;

    pay_t src0[$];
    pay_t src1[$];
    out_t sb_q[$];
    int   gnt_log[$];
    logic m_last;
    logic [7:0] m_addr;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic apply_inputs();
        bus.req0_valid = (src0.size() > 0);
        bus.req1_valid = (src1.size() > 0);
        if (src0.size() > 0) begin
            bus.req0_bank = src0[0].bank; bus.req0_addr = src0[0].addr; bus.req0_data = src0[0].data;
        end
        if (src1.size() > 0) begin
            bus.req1_bank = src1[0].bank; bus.req1_addr = src1[0].addr; bus.req1_data = src1[0].data;
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_addr = 8'h00;
        sb_q.delete();
        gnt_log.delete();
    endtask

    // One cycle per iteration: check readys, push the expected write, then pop and compare after the edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            logic v0, v1, g0, g1;
            pay_t p;
            out_t e, a;
            apply_inputs();
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            #1;
            g0 = v0 && (!v1 || m_last);
            g1 = v1 && (!v0 || !m_last);
            n_cmp++;
            if (bus.req0_ready !== g0 || bus.req1_ready !== g1) begin
                n_fail++;
                $display("FAIL ready cyc%0d: got r0=%b r1=%b want r0=%b r1=%b", c, bus.req0_ready, bus.req1_ready, g0, g1);
            end
            e.we = 4'b0; e.data = 64'b0; e.addr = m_addr;
            if (g0 || g1) begin
                p = g0 ? src0.pop_front() : src1.pop_front();
                e.we   = 4'b0001 << p.bank;
                e.data = 64'(p.data) << (16 * p.bank);
                e.addr = p.addr;
                m_addr = p.addr;
                m_last = g1;
                gnt_log.push_back(g1 ? 1 : 0);
            end
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            a = '{we: bank_we, addr: bank_addr, data: bank_data};
            e = sb_q.pop_front();
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL bank_out cyc%0d: got we=%h addr=%h data=%h want we=%h addr=%h data=%h",
                         c, a.we, a.addr, a.data, e.we, e.addr, e.data);
            end
        end
        apply_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src0.delete(); src1.delete();
        apply_inputs();
        bus3.req0_valid = 1'b0; bus3.req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #2;
    endtask

    task automatic test_reset();
        bus.req0_bank = '0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_bank = '0; bus.req1_addr = '0; bus.req1_data = '0;
        bus3.req0_bank = '0; bus3.req0_addr = '0; bus3.req0_data = '0;
        bus3.req1_bank = '0; bus3.req1_addr = '0; bus3.req1_data = '0;
        do_reset();
        n_cmp++;
        if (bank_we !== 4'b0 || bank_addr !== 8'h0 || bank_data !== 64'h0 || last_grant !== 1'b1 ||
            conflict_cnt !== 16'h0 || bad_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got we=%h addr=%h data=%h lg=%b cnt=%h bad=%b want 0 0 0 1 0 0",
                     bank_we, bank_addr, bank_data, last_grant, conflict_cnt, bad_bank);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b want r0=1 r1=0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_single();
        for (int k = 0; k < 8; k++) src0.push_back('{bank: 2'(k % 4), addr: 8'(k), data: 16'h100 + 16'(k)});
        run(8);
        n_cmp++;
        if (gnt_log.size() != 8) begin
            n_fail++;
            $display("FAIL single_grants: got %0d want 8", gnt_log.size());
        end
        run(1);
    endtask

    task automatic test_contention();
        logic [15:0] cnt_before;
        int want;
        do_reset();
        cnt_before = conflict_cnt;
        for (int k = 0; k < 6; k++) src0.push_back('{bank: 2'(k % 4), addr: 8'h20 + 8'(k), data: 16'hA000 + 16'(k)});
        for (int k = 0; k < 5; k++) src1.push_back('{bank: 2'((k + 2) % 4), addr: 8'h40 + 8'(k), data: 16'hB000 + 16'(k)});
        run(10);
        n_cmp++;
        if (conflict_cnt !== cnt_before + 16'd10) begin
            n_fail++;
            $display("FAIL conflict_cnt: got %0d want %0d", conflict_cnt, cnt_before + 16'd10);
        end
        for (int i = 0; i < 10; i++) begin
            want = i % 2;
            n_cmp++;
            if (gnt_log[i] != want) begin
                n_fail++;
                $display("FAIL alternate[%0d]: got %0d want %0d", i, gnt_log[i], want);
            end
        end
        run(2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) src0.push_back('{bank: 2'(k), addr: 8'h60 + 8'(k), data: 16'hC000 + 16'(k)});
        run(3);
        for (int k = 0; k < 3; k++) src1.push_back('{bank: 2'(3 - k), addr: 8'h70 + 8'(k), data: 16'hD000 + 16'(k)});
        apply_inputs();
        n_cmp++;
        if (bus.req0_valid !== 1'b0 || bus.req1_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL handoff_setup: got v0=%b v1=%b want 0 1", bus.req0_valid, bus.req1_valid);
        end
        run(1);
        n_cmp++;
        if (bank_we !== 4'b1000) begin
            n_fail++;
            $display("FAIL handoff_no_bubble: got we=%h want 8", bank_we);
        end
        run(3);
    endtask

    task automatic test_bad_bank();
        n_cmp++;
        if (bad_bank3 !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_bank_init: got %b want 0", bad_bank3);
        end
        bus3.req0_valid = 1'b1; bus3.req0_bank = 2'd3; bus3.req0_addr = 8'h05; bus3.req0_data = 16'hBEEF;
        #1;
        n_cmp++;
        if (bus3.req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_bank_ready: got %b want 1", bus3.req0_ready);
        end
        @(posedge clk); #1;
        bus3.req0_valid = 1'b0;
        n_cmp++;
        if (bank_we3 !== 4'b0 || bank_data3 !== 64'h0 || bad_bank3 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_bank_write: got we=%h data=%h bad=%b want 0 0 1", bank_we3, bank_data3, bad_bank3);
        end
        bus3.req1_valid = 1'b1; bus3.req1_bank = 2'd2; bus3.req1_addr = 8'h09; bus3.req1_data = 16'h1234;
        @(posedge clk); #1;
        bus3.req1_valid = 1'b0;
        n_cmp++;
        if (bank_we3 !== 4'b0100 || bank_data3 !== 64'h0000_1234_0000_0000 || bad_bank3 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_bank_sticky: got we=%h data=%h bad=%b want 4 0000123400000000 1",
                     bank_we3, bank_data3, bad_bank3);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bad_bank3 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_bank_hold: got %b want 1", bad_bank3);
        end
    endtask

    task automatic test_midstream_reset();
        src0.push_back('{bank: 2'd1, addr: 8'h33, data: 16'h5A5A});
        apply_inputs();
        @(posedge clk); #1;
        src0.delete();
        apply_inputs();
        n_cmp++;
        if (bank_we !== 4'b0010) begin
            n_fail++;
            $display("FAIL midreset_pending: got we=%h want 2", bank_we);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bank_we !== 4'b0 || bank_data !== 64'h0 || bank_addr !== 8'h0 || last_grant !== 1'b1 || bad_bank3 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got we=%h data=%h addr=%h lg=%b bad3=%b want 0 0 0 1 0",
                     bank_we, bank_data, bank_addr, last_grant, bad_bank3);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        bus.req0_valid = 1'b1; bus.req0_bank = 2'd0; bus.req0_addr = 8'h01; bus.req0_data = 16'h0001;
        bus.req1_valid = 1'b1; bus.req1_bank = 2'd1; bus.req1_addr = 8'h02; bus.req1_data = 16'h0002;
        repeat (70000) @(posedge clk);
        #1;
        n_cmp++;
        if (conflict_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate: got %h want ffff", conflict_cnt);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (conflict_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturate_hold: got %h want ffff", conflict_cnt);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus3.req0_valid = 1'b0; bus3.req1_valid = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_bad_bank();
        test_midstream_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
